alu_digit_serial: RTL and testbench

//   Parametrised multi-cycle ALU: WIDTH-bit operands processed DIGIT bits per clock, LSB digit first.

---
 rtl/alu_digit_serial.sv | 118 +++++++++++
 tb/tb_alu_digit_serial.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: WIDTH-bit ops processed DIGIT bits per cycle, LSB digit first, N/Z/C/V flags.
// Latency NDIG+1 cycles start->done; start is ignored while busy, one op per NDIG+1 cycles.
module alu_digit_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             c_in,
  input  logic [2:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             c_out,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       ctrl_q;
  logic             cy_q;

  logic             accept, last_dig;
  int unsigned      off;
  logic [DIGIT-1:0] dig_a, dig_b, dig_bp, dig_res;
  logic [DIGIT:0]   dig_sum;
  logic [WIDTH-1:0] res_full;
  logic             v_nxt;

  assign accept   = start && (state_q != S_RUN);
  assign last_dig = (cnt_q == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last_dig) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // One digit slice per RUN cycle; the adder chain runs for every op so C/V are always defined.
  always_comb begin
    off     = int'(cnt_q) * DIGIT;
    dig_a   = a_q[off +: DIGIT];
    dig_b   = b_q[off +: DIGIT];
    dig_bp  = ctrl_q[0] ? ~dig_b : dig_b;
    dig_sum = {1'b0, dig_a} + {1'b0, dig_bp} + {{DIGIT{1'b0}}, cy_q};
    case (ctrl_q[2:1])
      2'b00:   dig_res = dig_sum[DIGIT-1:0];
      2'b01:   dig_res = dig_a | dig_bp;
      2'b10:   dig_res = dig_a & dig_bp;
      default: dig_res = ctrl_q[0] ? ~dig_b : ~dig_a;
    endcase
    res_full = res_q;
    res_full[off +: DIGIT] = dig_res;
    // carry into the MSB recovered as a^b^sum at that bit
    v_nxt = dig_a[DIGIT-1] ^ dig_bp[DIGIT-1] ^ dig_sum[DIGIT-1] ^ dig_sum[DIGIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ctrl_q  <= '0;
      cy_q    <= 1'b0;
      alu_out <= '0;
      c_out   <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
      N       <= 1'b0;
    end else if (accept) begin
      a_q    <= in0;
      b_q    <= in1;
      cy_q   <= c_in;
      ctrl_q <= ctrl;
      cnt_q  <= '0;
    end else if (state_q == S_RUN) begin
      res_q <= res_full;
      cy_q  <= dig_sum[DIGIT];
      if (last_dig) begin
        cnt_q   <= '0;
        alu_out <= res_full;
        c_out   <= dig_sum[DIGIT];
        V       <= v_nxt;
        Z       <= (res_full == '0);
        N       <= res_full[WIDTH-1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_digit_serial.sv
// Directed and sweep bench for alu_digit_serial at WIDTH/DIGIT = 8/4, 4/1 and 8/8.
module tb_alu_digit_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic       st84 = 0, ci84 = 0, busy84, done84, co84, v84, z84, n84;
  logic [7:0] a84 = 0, b84 = 0, out84;
  logic [2:0] ct84 = 0;

  logic       st41 = 0, ci41 = 0, busy41, done41, co41, v41, z41, n41;
  logic [3:0] a41 = 0, b41 = 0, out41;
  logic [2:0] ct41 = 0;

  logic       st88 = 0, ci88 = 0, busy88, done88, co88, v88, z88, n88;
  logic [7:0] a88 = 0, b88 = 0, out88;
  logic [2:0] ct88 = 0;

  alu_digit_serial #(.WIDTH(8), .DIGIT(4)) u_d84 (
    .clk(clk), .rst_n(rst_n), .start(st84), .in0(a84), .in1(b84), .c_in(ci84), .ctrl(ct84),
    .busy(busy84), .done(done84), .alu_out(out84), .c_out(co84), .V(v84), .Z(z84), .N(n84));

  alu_digit_serial #(.WIDTH(4), .DIGIT(1)) u_d41 (
    .clk(clk), .rst_n(rst_n), .start(st41), .in0(a41), .in1(b41), .c_in(ci41), .ctrl(ct41),
    .busy(busy41), .done(done41), .alu_out(out41), .c_out(co41), .V(v41), .Z(z41), .N(n41));

  alu_digit_serial #(.WIDTH(8), .DIGIT(8)) u_d88 (
    .clk(clk), .rst_n(rst_n), .start(st88), .in0(a88), .in1(b88), .c_in(ci88), .ctrl(ct88),
    .busy(busy88), .done(done88), .alu_out(out88), .c_out(co88), .V(v88), .Z(z88), .N(n88));

  // Reference: {result[7:0], C, V, Z, N} for a w-bit ALU, built from integer arithmetic.
  function automatic logic [11:0] model(input int w, input int a, input int b,
                                        input logic [2:0] ct, input logic ci);
    int mask, bp, full, low, res, c, cm;
    logic [7:0] r8;
    mask = (1 << w) - 1;
    bp   = ct[0] ? (~b & mask) : b;
    full = a + bp + int'(ci);
    c    = (full >> w) & 1;
    low  = (a & (mask >> 1)) + (bp & (mask >> 1)) + int'(ci);
    cm   = (low >> (w - 1)) & 1;
    case (ct)
      3'd0, 3'd1: res = full & mask;
      3'd2, 3'd3: res = (a | bp) & mask;
      3'd4, 3'd5: res = a & bp;
      3'd6:       res = ~a & mask;
      default:    res = ~b & mask;
    endcase
    r8 = res[7:0];
    return {r8, c[0], c[0] ^ cm[0], res == 0, res[w-1]};
  endfunction

  // Stimulus only: issue one op on the 8/4 instance and count negedges until done (bounded).
  task automatic drive84(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [2:0] ct, output int lat);
    @(negedge clk);
    a84 = a; b84 = b; ci84 = ci; ct84 = ct; st84 = 1'b1;
    @(negedge clk);
    st84 = 1'b0;
    lat = 1;
    while (done84 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy84, done84, out84, co84, v84, z84, n84} !== 14'd0) begin
      failures++;
      $display("FAIL reset_84 got=%h want=0", {busy84, done84, out84, co84, v84, z84, n84});
    end
    checks++;
    if ({busy41, done41, out41, co41, v41, z41, n41} !== 10'd0) begin
      failures++;
      $display("FAIL reset_41 got=%h want=0", {busy41, done41, out41, co41, v41, z41, n41});
    end
    checks++;
    if ({busy88, done88, out88, co88, v88, z88, n88} !== 14'd0) begin
      failures++;
      $display("FAIL reset_88 got=%h want=0", {busy88, done88, out88, co88, v88, z88, n88});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int lat;
    logic [11:0] exp_v [3];
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic        vc [3];
    logic [2:0]  vt [3];
    va = '{8'h7F, 8'h05, 8'hF0};
    vb = '{8'h01, 8'h05, 8'h3C};
    vc = '{1'b0, 1'b1, 1'b0};
    vt = '{3'b000, 3'b001, 3'b101};
    // {alu_out, C, V, Z, N}
    exp_v = '{{8'h80, 4'b0101}, {8'h00, 4'b1010}, {8'hC0, 4'b1001}};
    for (int i = 0; i < 3; i++) begin
      drive84(va[i], vb[i], vc[i], vt[i], lat);
      checks++;
      if (lat !== 3) begin
        failures++;
        $display("FAIL directed%0d_latency got=%0d want=3", i, lat);
      end
      checks++;
      if ({out84, co84, v84, z84, n84} !== exp_v[i]) begin
        failures++;
        $display("FAIL directed%0d_result got=%h want=%h", i, {out84, co84, v84, z84, n84}, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a84 = 8'h12; b84 = 8'h34; ci84 = 0; ct84 = 3'b000; st84 = 1;
    @(negedge clk);
    a84 = 8'hFF; b84 = 8'hFF; ct84 = 3'b100; st84 = 1;
    @(negedge clk);
    st84 = 0;
    checks++;
    if ({busy84, done84} !== 2'b10) begin
      failures++;
      $display("FAIL ignore_start_busy got=%b want=10", {busy84, done84});
    end
    @(negedge clk);
    checks++;
    if ({done84, out84, co84, v84, z84, n84} !== {1'b1, 8'h46, 4'b0000}) begin
      failures++;
      $display("FAIL first_result got=%h want=%h", {done84, out84, co84, v84, z84, n84},
               {1'b1, 8'h46, 4'b0000});
    end
    a84 = 8'h0F; b84 = 8'hF0; ci84 = 0; ct84 = 3'b010; st84 = 1;
    @(negedge clk);
    st84 = 0;
    a84 = 8'h00; b84 = 8'h00;
    checks++;
    if ({busy84, done84, out84} !== {2'b10, 8'h46}) begin
      failures++;
      $display("FAIL second_accept_hold got=%h want=%h", {busy84, done84, out84}, {2'b10, 8'h46});
    end
    lat = 1;
    while (done84 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL second_latency got=%0d want=3", lat);
    end
    checks++;
    if ({out84, co84, v84, z84, n84} !== {8'hFF, 4'b0001}) begin
      failures++;
      $display("FAIL second_result got=%h want=%h", {out84, co84, v84, z84, n84}, {8'hFF, 4'b0001});
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic seen_done;
    @(negedge clk);
    a84 = 8'h01; b84 = 8'h01; ci84 = 0; ct84 = 3'b000; st84 = 1;
    @(negedge clk);
    st84 = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy84, done84, out84, co84, v84, z84, n84} !== 14'd0) begin
      failures++;
      $display("FAIL midrun_reset got=%h want=0", {busy84, done84, out84, co84, v84, z84, n84});
    end
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done84 !== 1'b0) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done84 !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_no_done got=%b want=0", seen_done);
    end
    drive84(8'h20, 8'h0F, 1'b0, 3'b111, lat);
    checks++;
    if (lat !== 3 || {out84, co84, v84, z84, n84} !== {8'hF0, 4'b1001}) begin
      failures++;
      $display("FAIL after_reset_op got=%0d/%h want=3/%h", lat, {out84, co84, v84, z84, n84},
               {8'hF0, 4'b1001});
    end
  endtask

  task automatic test_sweep_w4d1();
    int lat;
    logic [11:0] exp_v;
    for (int t = 0; t < 8; t++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            a41 = a[3:0]; b41 = b[3:0]; ci41 = c[0]; ct41 = t[2:0]; st41 = 1;
            @(negedge clk);
            st41 = 0;
            lat = 1;
            while (done41 !== 1'b1 && lat < 20) begin
              @(negedge clk);
              lat++;
            end
            exp_v = model(4, a, b, t[2:0], c[0]);
            checks++;
            if ({4'b0, out41, co41, v41, z41, n41} !== exp_v || lat !== 5) begin
              failures++;
              $display("FAIL w4d1 t=%0d c=%0d a=%h b=%h got=%h lat=%0d want=%h lat=5",
                       t, c, a, b, {4'b0, out41, co41, v41, z41, n41}, lat, exp_v);
            end
          end
  endtask

  task automatic test_sweep_w8d8();
    int lat, a, b;
    logic [11:0] exp_v;
    for (int t = 0; t < 8; t++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 16; i++)
          for (int j = 0; j < 16; j++) begin
            a = (i * 17) & 255;
            b = (j << 4) | (15 - j);
            @(negedge clk);
            a88 = a[7:0]; b88 = b[7:0]; ci88 = c[0]; ct88 = t[2:0]; st88 = 1;
            @(negedge clk);
            st88 = 0;
            lat = 1;
            while (done88 !== 1'b1 && lat < 20) begin
              @(negedge clk);
              lat++;
            end
            exp_v = model(8, a, b, t[2:0], c[0]);
            checks++;
            if ({out88, co88, v88, z88, n88} !== exp_v || lat !== 2) begin
              failures++;
              $display("FAIL w8d8 t=%0d c=%0d a=%h b=%h got=%h lat=%0d want=%h lat=2",
                       t, c, a, b, {out88, co88, v88, z88, n88}, lat, exp_v);
            end
          end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_w4d1();
    test_sweep_w8d8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
